// File: rtl/nfc_buf.sv
// nfc_buf: host <-> flash circular data buffer with direction-selected push/pop sides.
// Define NFC_BUF_LEVEL_EN to expose buf_level and buf_half.
module nfc_buf #(
  parameter int DAT_WID = 16,
  parameter int AW      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               buf_dir,
  input  logic               buf_flush,
  input  logic               host_wr,
  input  logic [DAT_WID-1:0] host_wdata,
  output logic               host_wr_rdy,
  input  logic               host_rd,
  output logic [DAT_WID-1:0] host_rdata,
  output logic               host_rd_vld,
  input  logic               nfif_data_rd,
  output logic               nfif_rd_rdy,
  output logic [DAT_WID-1:0] nfif_data_in,
  input  logic               nfif_data_wr,
  input  logic [DAT_WID-1:0] nfif_data_out,
  output logic               nfif_wr_rdy,
  output logic               buf_empty,
  output logic               buf_err
`ifdef NFC_BUF_LEVEL_EN
  ,
  output logic [AW:0]        buf_level,
  output logic               buf_half
`endif
);
  localparam int DEPTH = 1 << AW;
  logic [DAT_WID-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [AW:0]        r_level;
  logic               r_pend, r_err, r_host_vld, r_nfif_rdy;
  logic [DAT_WID-1:0] r_host_dat, r_nfif_dat;
  logic               w_full, w_empty, w_push_req, w_pop_req, w_push, w_pop, w_ovf, w_unf;
  logic [DAT_WID-1:0] w_push_dat;
  assign w_full     = r_level == (AW+1)'(DEPTH);
  assign w_empty    = r_level == '0;
  assign w_push_req = buf_dir ? host_wr : nfif_data_wr;
  assign w_push_dat = buf_dir ? host_wdata : nfif_data_out;
  // A parked flash-side request keeps asking until data arrives
  assign w_pop_req  = buf_dir ? (nfif_data_rd | r_pend) : host_rd;
  assign w_pop      = w_pop_req & !w_empty;
  assign w_push     = w_push_req & (!w_full | w_pop);
  assign w_ovf      = w_push_req & w_full & !w_pop;
  assign w_unf      = !buf_dir & host_rd & w_empty;
  assign host_wr_rdy  = !w_full & buf_dir;
  assign nfif_wr_rdy  = !w_full & !buf_dir;
  assign buf_empty    = w_empty;
  assign buf_err      = r_err;
  assign host_rdata   = r_host_dat;
  assign host_rd_vld  = r_host_vld;
  assign nfif_data_in = r_nfif_dat;
  assign nfif_rd_rdy  = r_nfif_rdy;
`ifdef NFC_BUF_LEVEL_EN
  assign buf_level = r_level;
  assign buf_half  = r_level >= (AW+1)'(DEPTH / 2);
`endif
  always_ff @(posedge clk) begin
    if (w_push & !buf_flush) r_mem[r_wr_ptr] <= w_push_dat;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_pend     <= 1'b0;
      r_err      <= 1'b0;
      r_host_vld <= 1'b0;
      r_nfif_rdy <= 1'b0;
      r_host_dat <= '0;
      r_nfif_dat <= '0;
    end else if (buf_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_pend     <= 1'b0;
      r_err      <= 1'b0;
      r_host_vld <= 1'b0;
      r_nfif_rdy <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      if (buf_dir & w_pop) r_pend <= 1'b0;
      else if (buf_dir & nfif_data_rd & w_empty) r_pend <= 1'b1;
      if (w_ovf | w_unf) r_err <= 1'b1;
      r_host_vld <= w_pop & !buf_dir;
      r_nfif_rdy <= w_pop & buf_dir;
      if (w_pop & !buf_dir) r_host_dat <= r_mem[r_rd_ptr];
      if (w_pop & buf_dir) r_nfif_dat <= r_mem[r_rd_ptr];
    end
  end
endmodule

// File: tb/tb_nfc_buf.sv
// tb_nfc_buf: scoreboard bench for nfc_buf; pushes queue expected words, output pulses pop and compare.
module tb_nfc_buf;
  logic        clk = 1'b0;
  logic        rst_n, dir, buf_flush;
  logic        host_wr, host_wr_rdy, host_rd, host_rd_vld;
  logic [15:0] host_wdata, host_rdata;
  logic        nfif_data_rd, nfif_rd_rdy, nfif_data_wr, nfif_wr_rdy;
  logic [15:0] nfif_data_in, nfif_data_out;
  logic        buf_empty, buf_err;
`ifdef NFC_BUF_LEVEL_EN
  logic [4:0]  buf_level;
  logic        buf_half;
`endif
  int          n_cmp = 0, n_bad = 0, pulses = 0, base;
  logic [15:0] sb [$];

  always #5 clk = ~clk;

  nfc_buf dut (
    .clk(clk), .rst_n(rst_n), .buf_dir(dir), .buf_flush(buf_flush),
    .host_wr(host_wr), .host_wdata(host_wdata), .host_wr_rdy(host_wr_rdy),
    .host_rd(host_rd), .host_rdata(host_rdata), .host_rd_vld(host_rd_vld),
    .nfif_data_rd(nfif_data_rd), .nfif_rd_rdy(nfif_rd_rdy), .nfif_data_in(nfif_data_in),
    .nfif_data_wr(nfif_data_wr), .nfif_data_out(nfif_data_out), .nfif_wr_rdy(nfif_wr_rdy),
    .buf_empty(buf_empty), .buf_err(buf_err)
`ifdef NFC_BUF_LEVEL_EN
    , .buf_level(buf_level), .buf_half(buf_half)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (nfif_rd_rdy || host_rd_vld)) begin
      pulses++;
      if (sb.size() == 0) check("pulse_without_expected_word", 32'(sb.size()), 32'd1);
      else check(nfif_rd_rdy ? "nfif_data" : "host_data",
                 nfif_rd_rdy ? 32'(nfif_data_in) : 32'(host_rdata), 32'(sb.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    if (dir) begin host_wr = 1'b1; host_wdata = d; end
    else begin nfif_data_wr = 1'b1; nfif_data_out = d; end
    sb.push_back(d);
    step();
    host_wr = 1'b0;
    nfif_data_wr = 1'b0;
  endtask

  task automatic pop_one();
    if (dir) nfif_data_rd = 1'b1;
    else host_rd = 1'b1;
    step();
    nfif_data_rd = 1'b0;
    host_rd = 1'b0;
  endtask

  task automatic flush();
    buf_flush = 1'b1;
    step();
    buf_flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; dir = 1'b1; buf_flush = 1'b0;
    host_wr = 1'b0; host_wdata = '0; host_rd = 1'b0;
    nfif_data_rd = 1'b0; nfif_data_wr = 1'b0; nfif_data_out = '0;
    #3;
    check("rst_empty", buf_empty, 1);
    check("rst_err", buf_err, 0);
    check("rst_nfif_rdy", nfif_rd_rdy, 0);
    check("rst_host_vld", host_rd_vld, 0);
    check("rst_nfif_data", nfif_data_in, 0);
    check("rst_host_data", host_rdata, 0);
    check("rst_host_wr_rdy_dir1", host_wr_rdy, 1);
    check("rst_nfif_wr_rdy_dir1", nfif_wr_rdy, 0);
    dir = 1'b0;
    #1;
    check("rst_host_wr_rdy_dir0", host_wr_rdy, 0);
    check("rst_nfif_wr_rdy_dir0", nfif_wr_rdy, 1);
    dir = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();

    // Program direction: fill to full, then drain from flash side
    for (int i = 1; i <= 16; i++) push(i == 16 ? 16'h1010 : 16'(i * 16'h1111));
    check("full_host_wr_rdy", host_wr_rdy, 0);
    check("full_not_empty", buf_empty, 0);
    base = pulses;
    for (int i = 0; i < 16; i++) begin
      pop_one();
      check("nfif_rdy_latency", nfif_rd_rdy, 1);
    end
    check("drain_empty", buf_empty, 1);
    step();
    check("drain_pulses", 32'(pulses - base), 16);
    check("drain_sb", 32'(sb.size()), 0);

    // Pending flash read served once data shows up
    flush();
    base = pulses;
    pop_one();
    step(); step();
    check("pend_idle", nfif_rd_rdy, 0);
    push(16'hABCD);
    check("pend_wait", nfif_rd_rdy, 0);
    step();
    check("pend_rdy", nfif_rd_rdy, 1);
    check("pend_data", nfif_data_in, 16'hABCD);
    step(); step(); step();
    check("pend_once", 32'(pulses - base), 1);
    check("pend_empty", buf_empty, 1);
    check("pend_err", buf_err, 0);

    // Read direction: full, simultaneous push/pop, overflow, flush, underflow
    flush();
    dir = 1'b0;
    for (int i = 1; i <= 16; i++) push(16'(i));
    check("rd_full_wr_rdy", nfif_wr_rdy, 0);
    nfif_data_wr = 1'b1; nfif_data_out = 16'h7777; host_rd = 1'b1;
    sb.push_back(16'h7777);
    step();
    nfif_data_wr = 1'b0; host_rd = 1'b0;
    check("full_pushpop_err", buf_err, 0);
    check("full_pushpop_still_full", nfif_wr_rdy, 0);
    nfif_data_wr = 1'b1; nfif_data_out = 16'h5A5A;
    step();
    nfif_data_wr = 1'b0;
    check("ovf_err", buf_err, 1);
    check("ovf_still_full", nfif_wr_rdy, 0);
    for (int i = 0; i < 16; i++) pop_one();
    step();
    check("ovf_drain_empty", buf_empty, 1);
    check("ovf_err_sticky", buf_err, 1);
    check("ovf_drain_sb", 32'(sb.size()), 0);
    flush();
    check("flush_err", buf_err, 0);
    check("flush_empty", buf_empty, 1);
    check("flush_wr_rdy", nfif_wr_rdy, 1);
    base = pulses;
    pop_one();
    step();
    check("unf_err", buf_err, 1);
    check("unf_no_pulse", 32'(pulses - base), 0);
    flush();

    // Pointer wrap with overlapping push/pop
    for (int i = 0; i < 17; i++) begin
      nfif_data_wr = 1'b1;
      nfif_data_out = 16'hC000 + 16'(i);
      sb.push_back(16'hC000 + 16'(i));
      host_rd = (i >= 2);
      step();
    end
    nfif_data_wr = 1'b0; host_rd = 1'b0;
    pop_one(); pop_one();
    step();
    check("wrap_empty", buf_empty, 1);
    check("wrap_sb", 32'(sb.size()), 0);
    check("wrap_err", buf_err, 0);

    // Reset with words stored and a flash request parked
    flush();
    dir = 1'b1;
    pop_one();
    dir = 1'b0;
    for (int i = 0; i < 5; i++) push(16'h3000 + 16'(i));
    check("parked_not_served", nfif_rd_rdy, 0);
    check("parked_not_empty", buf_empty, 0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_empty", buf_empty, 1);
    step();
    rst_n = 1'b1;
    base = pulses;
    dir = 1'b1;
    step();
    check("postrst_empty", buf_empty, 1);
    check("postrst_rdy", nfif_rd_rdy, 0);
    step(); step(); step();
    check("postrst_no_pulse", 32'(pulses - base), 0);

`ifdef NFC_BUF_LEVEL_EN
    flush();
    for (int i = 0; i < 8; i++) push(16'h4000 + 16'(i));
    check("lvl8", buf_level, 8);
    check("half8", buf_half, 1);
    pop_one();
    check("lvl7", buf_level, 7);
    check("half7", buf_half, 0);
    for (int i = 0; i < 7; i++) pop_one();
    step();
    check("lvl0", buf_level, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
